// File: rtl/adder_pkg.sv
// Shared types and width helpers for the accumulating adder.
package adder_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Result width that can hold num_terms full-scale terms of in_width bits.
    function automatic int unsigned out_width(input int unsigned in_width,
                                              input int unsigned num_terms);
        return in_width + $clog2(num_terms);
    endfunction

endpackage

// File: rtl/full_adder_n_bit.sv
// Combinational WIDTH-bit adder with carry out in the top SUM bit.
module full_adder_n_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   SUM
);

    assign SUM = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/accumulating_adder.sv
// Sums NUM_TERMS handshaked terms, then holds the result until taken.
module accumulating_adder
    import adder_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = 1,
    parameter  int unsigned NUM_TERMS = 8,
    localparam int unsigned OUT_WIDTH = out_width(IN_WIDTH, NUM_TERMS),
    localparam int unsigned CNT_WIDTH = $clog2(NUM_TERMS) + 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLEAR,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [IN_WIDTH-1:0]  IN_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OUT_WIDTH-1:0] SUM,
    output logic [CNT_WIDTH-1:0] TERM_COUNT
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_TERMS - 1);

    state_e                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [OUT_WIDTH:0]     add_full;
    logic [OUT_WIDTH-1:0]   add_sum;
    logic                   add_carry_unused;

    // Accumulator can never exceed OUT_WIDTH bits, so the carry is dropped.
    full_adder_n_bit #(
        .WIDTH (OUT_WIDTH)
    ) u_add (
        .A   (acc_q),
        .B   (OUT_WIDTH'(IN_DATA)),
        .SUM (add_full)
    );

    assign {add_carry_unused, add_sum} = add_full;

    // Next-state: CLEAR overrides both handshakes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (CLEAR) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (IN_VALID) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY   = (state_q == ACCUM);
    assign OUT_VALID  = (state_q == HOLD);
    assign SUM        = acc_q;
    assign TERM_COUNT = cnt_q;

endmodule

// File: tb/tb_accumulating_adder.sv
// Four parameterisations driven by shared stimulus, checked against a term-count/sum model.
module tb_accumulating_adder;

    localparam int unsigned NT [4] = '{8, 8, 2, 5};
    localparam int unsigned IW [4] = '{1, 3, 3, 4};

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, out_ready;
    logic [3:0]  in_data;
    logic [3:0]  o_vld, o_rdy;
    logic [15:0] o_sum [4];
    logic [15:0] o_cnt [4];

    logic [3:0] s0;  logic [3:0] c0;
    logic [5:0] s1;  logic [3:0] c1;
    logic [3:0] s2;  logic [1:0] c2;
    logic [6:0] s3;  logic [3:0] c3;

    int tests = 0;
    int fails = 0;
    int msum [4];
    int mcnt [4];

    always #5 clk = ~clk;

    accumulating_adder #(.IN_WIDTH(1), .NUM_TERMS(8)) u_d0 (
        .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .IN_VALID(in_valid), .IN_READY(o_rdy[0]),
        .IN_DATA(in_data[0:0]), .OUT_VALID(o_vld[0]), .OUT_READY(out_ready),
        .SUM(s0), .TERM_COUNT(c0));
    accumulating_adder #(.IN_WIDTH(3), .NUM_TERMS(8)) u_d1 (
        .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .IN_VALID(in_valid), .IN_READY(o_rdy[1]),
        .IN_DATA(in_data[2:0]), .OUT_VALID(o_vld[1]), .OUT_READY(out_ready),
        .SUM(s1), .TERM_COUNT(c1));
    accumulating_adder #(.IN_WIDTH(3), .NUM_TERMS(2)) u_d2 (
        .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .IN_VALID(in_valid), .IN_READY(o_rdy[2]),
        .IN_DATA(in_data[2:0]), .OUT_VALID(o_vld[2]), .OUT_READY(out_ready),
        .SUM(s2), .TERM_COUNT(c2));
    accumulating_adder #(.IN_WIDTH(4), .NUM_TERMS(5)) u_d3 (
        .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .IN_VALID(in_valid), .IN_READY(o_rdy[3]),
        .IN_DATA(in_data), .OUT_VALID(o_vld[3]), .OUT_READY(out_ready),
        .SUM(s3), .TERM_COUNT(c3));

    assign o_sum[0] = 16'(s0);  assign o_cnt[0] = 16'(c0);
    assign o_sum[1] = 16'(s1);  assign o_cnt[1] = 16'(c1);
    assign o_sum[2] = 16'(s2);  assign o_cnt[2] = 16'(c2);
    assign o_sum[3] = 16'(s3);  assign o_cnt[3] = 16'(c3);

    // Model: a block holds when it has NUM_TERMS terms; its sum is the running total of masked terms.
    task automatic tick(input logic v, input logic [3:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (c) begin
                msum[k] = 0;
                mcnt[k] = 0;
            end else if (mcnt[k] == int'(NT[k])) begin
                if (r) begin
                    msum[k] = 0;
                    mcnt[k] = 0;
                end
            end else if (v) begin
                msum[k] += int'(32'(d) & ((32'd1 << IW[k]) - 32'd1));
                mcnt[k] += 1;
            end
        end
        #1;
    endtask

    task automatic model_zero();
        for (int k = 0; k < 4; k++) begin
            msum[k] = 0;
            mcnt[k] = 0;
        end
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !== {16'd0, 16'd0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset_low d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want 0 0 0 1",
                         k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]);
            end
        end
        in_valid = 1'b1;
        in_data  = 4'd1;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (o_cnt[k] !== 16'd0 || o_vld[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_release_pre_edge d%0d: cnt=%0d vld=%b, want 0 0", k, o_cnt[k], o_vld[k]);
            end
        end
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (o_cnt[k] !== 16'd1 || o_sum[k] !== 16'd1) begin
                fails++;
                $display("FAIL reset_first_edge d%0d: sum=%0d cnt=%0d, want 1 1", k, o_sum[k], o_cnt[k]);
            end
        end
    endtask

    task automatic test_pattern();
        logic [7:0] pat;
        pat = 8'b1110_1101;
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, {3'b000, pat[i]}, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                    {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                    fails++;
                    $display("FAIL pattern_model d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                             k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                end
            end
        end
        tests++;
        if (o_vld[0] !== 1'b1 || o_sum[0] !== 16'd6) begin
            fails++;
            $display("FAIL pattern_sum: vld=%b sum=%0d, want 1 6", o_vld[0], o_sum[0]);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        tests++;
        if (o_cnt[0] !== 16'd0 || o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL pattern_taken: cnt=%0d vld=%b rdy=%b, want 0 0 1", o_cnt[0], o_vld[0], o_rdy[0]);
        end
    endtask

    task automatic test_hold();
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 4'd7, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                    {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                    fails++;
                    $display("FAIL hold_model d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                             k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'd7, 1'b0, 1'b0);
            tests++;
            if (o_sum[1] !== 16'd56 || o_vld[1] !== 1'b1 || o_rdy[1] !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable cyc%0d: sum=%0d vld=%b rdy=%b, want 56 1 0",
                         i, o_sum[1], o_vld[1], o_rdy[1]);
            end
        end
        tick(1'b1, 4'd7, 1'b1, 1'b0);
        tests++;
        if (o_vld[1] !== 1'b0 || o_cnt[1] !== 16'd0 || o_sum[1] !== 16'd0) begin
            fails++;
            $display("FAIL hold_no_bypass: vld=%b cnt=%0d sum=%0d, want 0 0 0", o_vld[1], o_cnt[1], o_sum[1]);
        end
        tick(1'b1, 4'd7, 1'b0, 1'b0);
        tests++;
        if (o_cnt[1] !== 16'd1 || o_sum[1] !== 16'd7) begin
            fails++;
            $display("FAIL hold_next_accept: cnt=%0d sum=%0d, want 1 7", o_cnt[1], o_sum[1]);
        end
    endtask

    task automatic test_sweep();
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                tick(1'b1, 4'(a), 1'b0, 1'b0);
                tick(1'b1, 4'(b), 1'b0, 1'b0);
                tests++;
                if (o_vld[2] !== 1'b1 || o_sum[2] !== 16'(a + b)) begin
                    fails++;
                    $display("FAIL sweep a=%0d b=%0d: vld=%b sum=%0d, want 1 %0d", a, b, o_vld[2], o_sum[2], a + b);
                end
                tick(1'b0, 4'd0, 1'b1, 1'b0);
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                        {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                        fails++;
                        $display("FAIL sweep_model d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                                 k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (4) tick(1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 4'd1, 1'b0, 1'b1);
        tests++;
        if (o_cnt[0] !== 16'd0 || o_sum[0] !== 16'd0) begin
            fails++;
            $display("FAIL clear_priority: cnt=%0d sum=%0d, want 0 0", o_cnt[0], o_sum[0]);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 4'd1, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                    {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                    fails++;
                    $display("FAIL clear_model d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                             k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                end
            end
        end
        tests++;
        if (o_vld[0] !== 1'b1 || o_sum[0] !== 16'd8) begin
            fails++;
            $display("FAIL clear_then_sum: vld=%b sum=%0d, want 1 8", o_vld[0], o_sum[0]);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (5) tick(1'b1, 4'd1, 1'b0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            #2;
            rst_n = 1'b0;
            model_zero();
            #1;
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !== {16'd0, 16'd0, 1'b0, 1'b1}) begin
                    fails++;
                    $display("FAIL async_reset pass%0d d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want 0 0 0 1",
                             pass, k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]);
                end
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                tests++;
                if (o_vld !== 4'b0000) begin
                    fails++;
                    $display("FAIL async_reset_vld pass%0d: vld=%b, want 0000", pass, o_vld);
                end
            end
            #3;
            rst_n = 1'b1;
            if (pass == 0) begin
                repeat (8) tick(1'b1, 4'd1, 1'b0, 1'b0);
                tests++;
                if (o_vld[0] !== 1'b1 || o_sum[0] !== 16'd8) begin
                    fails++;
                    $display("FAIL async_refill: vld=%b sum=%0d, want 1 8", o_vld[0], o_sum[0]);
                end
            end
        end
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !== {16'd0, 16'd0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL async_after d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want 0 0 0 1",
                         k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]);
            end
        end
    endtask

    task automatic test_gaps();
        int guard;
        guard = 0;
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        while (mcnt[3] < 5 && guard < 200) begin
            tick(1'($urandom_range(0, 1)), 4'd15, 1'b0, 1'b0);
            guard++;
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                    {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                    fails++;
                    $display("FAIL gaps_model d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                             k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                end
            end
        end
        tests++;
        if (o_vld[3] !== 1'b1 || o_sum[3] !== 16'd75 || o_cnt[3] !== 16'd5) begin
            fails++;
            $display("FAIL gaps_sum: vld=%b sum=%0d cnt=%0d after %0d cycles, want 1 75 5",
                     o_vld[3], o_sum[3], o_cnt[3], guard);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({o_sum[k], o_cnt[k], o_vld[k], o_rdy[k]} !==
                    {16'(msum[k]), 16'(mcnt[k]), mcnt[k] == int'(NT[k]), mcnt[k] != int'(NT[k])}) begin
                    fails++;
                    $display("FAIL random_model cyc%0d d%0d: sum=%0d cnt=%0d vld=%b rdy=%b, want sum=%0d cnt=%0d",
                             i, k, o_sum[k], o_cnt[k], o_vld[k], o_rdy[k], msum[k], mcnt[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        model_zero();
        test_reset();
        model_zero();
        msum[0] = 1; msum[1] = 1; msum[2] = 1; msum[3] = 1;
        mcnt[0] = 1; mcnt[1] = 1; mcnt[2] = 1; mcnt[3] = 1;
        test_pattern();
        test_hold();
        test_sweep();
        test_clear();
        test_async_reset();
        test_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
